updown_counter: RTL and testbench

Parametrised successor to the team's free-running 8-bit counter: a synchronous up/down counter with programmable width and top value, parallel load, count enable, wrap or saturate mode, and a registered terminal-count pulse. Used as a general-purpose timer/event counter wherever a plain free-running counter is insufficient. Single clock domain, all outputs registered.

---
 rtl/updown_counter.sv | 107 ++++++++++
 tb/tb_updown_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Synchronous up/down counter with programmable width and top value,
// parallel load with clamping, count enable, wrap/saturate mode and a
// registered terminal-count pulse. Priority per edge: reset > load > step.
//
// Optional feature: define COUNTER_PRESCALE_EN to divide the enable by
// PRESCALE, so that only every PRESCALE-th enabled cycle is a step.
// Without the macro every enabled cycle is a step and PRESCALE is unused.
module updown_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
    parameter int               PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             tc
);

    // Elaboration-time sanity checks on the parameters.
    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter: WIDTH must be >= 2");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("updown_counter: PRESCALE must be >= 2");
    end

    logic [WIDTH-1:0] r_value;
    logic             r_tc;
    logic             w_step;
    logic [WIDTH-1:0] w_next_value;
    logic             w_next_tc;

`ifdef COUNTER_PRESCALE_EN
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_prescale;

    // A step happens only on the enabled cycle that completes a prescale interval.
    always_comb begin
        w_step = en && (r_prescale == PS_LAST);
    end

    // Prescaler: counts enabled cycles, holds while idle, cleared by reset and load.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_prescale <= '0;
        end else if (en) begin
            r_prescale <= w_step ? '0 : r_prescale + PS_W'(1);
        end
    end
`else
    // Every enabled cycle is a step.
    always_comb begin
        w_step = en;
    end
`endif

    // Next value and terminal-count flag from load, direction and mode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave it unassigned and infer a latch.
        w_next_value = r_value;
        w_next_tc    = 1'b0;
        if (load) begin
            w_next_value = (load_value > MAX) ? MAX : load_value;
        end else if (w_step) begin
            if (up) begin
                if (r_value == MAX) begin
                    w_next_tc    = 1'b1;
                    w_next_value = sat ? MAX : '0;
                end else begin
                    w_next_value = r_value + WIDTH'(1);
                end
            end else begin
                if (r_value == '0) begin
                    w_next_tc    = 1'b1;
                    w_next_value = sat ? '0 : MAX;
                end else begin
                    w_next_value = r_value - WIDTH'(1);
                end
            end
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset) begin
            r_value <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_value <= w_next_value;
            r_tc    <= w_next_tc;
        end
    end

    assign value = r_value;
    assign tc    = r_tc;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter. Two instances share stimulus:
// dut_a uses the full 8-bit range (MAX=255), dut_b uses MAX=9. A behavioural
// model predicts both on every driven cycle and pushes the prediction into a
// scoreboard queue; a monitor pops and compares after each rising edge.
// Works with or without COUNTER_PRESCALE_EN defined.
module tb_updown_counter;

`ifdef COUNTER_PRESCALE_EN
    localparam int PS_DIV = 4;
`else
    localparam int PS_DIV = 1;
`endif

    localparam int MAX_A = 255;
    localparam int MAX_B = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic [7:0] value_a, value_b;
    logic       tc_a, tc_b;

    typedef struct {
        logic [7:0] va;
        logic       ta;
        logic [7:0] vb;
        logic       tb;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    int num_checks = 0;
    int num_errors = 0;

    // Model state.
    int m_va = 0, m_psa = 0, m_vb = 0, m_psb = 0;

    updown_counter #(.WIDTH(8), .PRESCALE(4)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_value(load_value), .value(value_a), .tc(tc_a)
    );

    updown_counter #(.WIDTH(8), .MAX(8'd9), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_value(load_value), .value(value_b), .tc(tc_b)
    );

    always #5 clk = ~clk;

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_step(input int maxv, inout int val, inout int ps, output bit t);
        bit do_step;
        t = 1'b0;
        do_step = 1'b0;
        if (reset) begin
            val = 0;
            ps  = 0;
        end else if (load) begin
            val = (int'(load_value) > maxv) ? maxv : int'(load_value);
            ps  = 0;
        end else if (en) begin
            if (ps == PS_DIV - 1) begin
                ps = 0;
                do_step = 1'b1;
            end else begin
                ps = ps + 1;
            end
        end
        if (do_step) begin
            if (up) begin
                if (val == maxv) begin
                    t = 1'b1;
                    if (!sat) val = 0;
                end else begin
                    val = val + 1;
                end
            end else begin
                if (val == 0) begin
                    t = 1'b1;
                    if (!sat) val = maxv;
                end else begin
                    val = val - 1;
                end
            end
        end
    endtask

    // Predict this cycle, push to the scoreboard, advance past the edge.
    task automatic tick(input string tag);
        exp_t e;
        bit   ta, tb;
        model_step(MAX_A, m_va, m_psa, ta);
        model_step(MAX_B, m_vb, m_psb, tb);
        e.va  = 8'(m_va);
        e.ta  = ta;
        e.vb  = 8'(m_vb);
        e.tb  = tb;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                num_checks += 4;
                if (value_a !== e.va) begin
                    num_errors++;
                    $display("FAIL %s value_a: got %0d expected %0d", e.tag, value_a, e.va);
                end
                if (tc_a !== e.ta) begin
                    num_errors++;
                    $display("FAIL %s tc_a: got %b expected %b", e.tag, tc_a, e.ta);
                end
                if (value_b !== e.vb) begin
                    num_errors++;
                    $display("FAIL %s value_b: got %0d expected %0d", e.tag, value_b, e.vb);
                end
                if (tc_b !== e.tb) begin
                    num_errors++;
                    $display("FAIL %s tc_b: got %b expected %b", e.tag, tc_b, e.tb);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        tick("reset");
        tick("reset_hold");
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b0;
        repeat (258 * PS_DIV) tick("free_run");
    endtask

    task automatic test_modulo_down();
        load = 1'b1; load_value = 8'd2; en = 1'b0;
        tick("down_load");
        load = 1'b0; up = 1'b0; sat = 1'b0; en = 1'b1;
        repeat (5 * PS_DIV) tick("modulo_down");
    endtask

    task automatic test_saturate();
        load = 1'b1; load_value = 8'd8; en = 1'b0; up = 1'b1; sat = 1'b1;
        tick("sat_load");
        load = 1'b0; en = 1'b1;
        repeat (4 * PS_DIV) tick("saturate_up");
        load = 1'b1; load_value = 8'd1; en = 1'b0;
        tick("sat_load_low");
        load = 1'b0; up = 1'b0; en = 1'b1;
        repeat (4 * PS_DIV) tick("saturate_down");
        en = 1'b0;
        repeat (2) tick("idle_hold");
    endtask

    task automatic test_load_priority();
        sat = 1'b0; up = 1'b1;
        load = 1'b1; en = 1'b1; load_value = 8'd12;
        tick("load_clamp");
        reset = 1'b1;
        tick("reset_over_load");
        reset = 1'b0; load = 1'b0;
        load = 1'b1; en = 1'b0; load_value = 8'd255;
        tick("load_max");
        load = 1'b0; en = 1'b1;
        repeat (2 * PS_DIV) tick("after_load_max");
    endtask

    task automatic test_prescale_phase();
        reset = 1'b1;
        tick("ps_reset");
        reset = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        repeat (6) tick("ps_run");
        en = 1'b0;
        repeat (2) tick("ps_pause");
        en = 1'b1;
        repeat (6) tick("ps_resume");
        load = 1'b1; load_value = 8'd5;
        tick("ps_load_clear");
        load = 1'b0;
        repeat (9) tick("ps_after_load");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            load       = ($urandom_range(0, 15) == 0);
            en         = ($urandom_range(0, 3) != 0);
            up         = $urandom_range(0, 1);
            sat        = ($urandom_range(0, 3) == 0);
            load_value = 8'($urandom_range(0, 255));
            tick("random");
        end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_modulo_down();
        test_saturate();
        test_load_priority();
        test_prescale_phase();
        test_random();
        tick("drain");
        num_checks++;
        if (exp_q.size() != 0) begin
            num_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
